fetch_stage_regs: RTL and testbench

- Fetch-side consumer of the load-use stall signals.
- Owns the program counter, next-PC selection and the IF/ID pipeline register.
- Honours PCWrite / IF_ID_Write from the hazard detection unit, redirects on jump/branch/exception, and flushes the fetched slot to a NOP bubble on redirect.
- Sits between instruction memory (asynchronous read) and the ID stage.

---
 rtl/fetch_stage_regs.sv | 102 ++++++++++
 tb/tb_fetch_stage_regs.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_regs.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Optional FETCH_STALL_COUNT_EN adds a saturating Stall_Count output.
module fetch_stage_regs #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Exception,
  input  logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic        IF_ID_Valid
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] Stall_Count
`endif
);

  localparam logic [31:0] RESET_PC_W   = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] EXC_VECTOR_W = {EXC_VECTOR[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] pc_plus4;
  logic        redirect;

  // Target word-offset bits are deliberately dropped; PC stays word aligned.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^{Jump_Target[1:0], Branch_Target[1:0]};

  always_comb begin
    redirect = Exception | Branch_Taken | Jump;
    pc_plus4 = pc_q + 32'd4;

    pc_d = pc_q;
    if (Exception)         pc_d = EXC_VECTOR_W;
    else if (Branch_Taken) pc_d = {Branch_Target[31:2], 2'b00};
    else if (Jump)         pc_d = {Jump_Target[31:2], 2'b00};
    else if (PCWrite)      pc_d = pc_plus4;

    if_id_instr_d    = if_id_instr_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_valid_d    = if_id_valid_q;
    // A flush wins over a held IF/ID; PC+4 is kept since the bubble never uses it.
    if (redirect) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (IF_ID_Write) begin
      if_id_instr_d    = Instr;
      if_id_pc_plus4_d = pc_plus4;
      if_id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_PC_W;
      if_id_instr_q    <= NOP_INSTR;
      if_id_pc_plus4_q <= 32'd0;
      if_id_valid_q    <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign PC             = pc_q;
  assign IF_ID_Instr    = if_id_instr_q;
  assign IF_ID_PC_Plus4 = if_id_pc_plus4_q;
  assign IF_ID_Valid    = if_id_valid_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && !redirect && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_regs.sv
// Directed bench for fetch_stage_regs: per-cycle reference model compare plus literal checks.
module tb_fetch_stage_regs;

  logic        clk;
  logic        reset;
  logic        PCWrite, IF_ID_Write, Jump, Branch_Taken, Exception;
  logic [31:0] Jump_Target, Branch_Target, Instr;
  logic [31:0] PC, IF_ID_Instr, IF_ID_PC_Plus4;
  logic        IF_ID_Valid;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] Stall_Count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_regs dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Jump(Jump), .Jump_Target(Jump_Target),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Exception(Exception), .Instr(Instr),
    .PC(PC), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PC_Plus4(IF_ID_PC_Plus4), .IF_ID_Valid(IF_ID_Valid)
`ifdef FETCH_STALL_COUNT_EN
    , .Stall_Count(Stall_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state updated from the rules each rising edge.
  logic [31:0] m_pc, m_instr, m_plus4, m_cnt;
  logic        m_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_plus4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      logic [31:0] seq_pc;
      logic        flush;
      seq_pc = m_pc + 32'd4;
      flush  = Exception || Branch_Taken || Jump;
      if (flush) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (IF_ID_Write) begin
        m_instr = Instr; m_plus4 = seq_pc; m_valid = 1'b1;
      end
      if (!PCWrite && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (Exception)         m_pc = 32'h8000_0004;
      else if (Branch_Taken) m_pc = Branch_Target & ~32'h3;
      else if (Jump)         m_pc = Jump_Target & ~32'h3;
      else if (PCWrite)      m_pc = seq_pc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("model_pc", PC, m_pc);
      chk("model_instr", IF_ID_Instr, m_instr);
      chk("model_plus4", IF_ID_PC_Plus4, m_plus4);
      chk("model_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
`ifdef FETCH_STALL_COUNT_EN
      chk("model_cnt", Stall_Count, m_cnt);
`endif
    end
  end

  task automatic step(input logic pcw, input logic ifw, input logic j, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt, input logic exc,
                      input logic [31:0] ins);
    PCWrite = pcw; IF_ID_Write = ifw; Jump = j; Jump_Target = jt;
    Branch_Taken = br; Branch_Target = bt; Exception = exc; Instr = ins;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [31:0] ins);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0, ins);
  endtask

  task automatic chk_if(input string name, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] p4, input logic v);
    chk({name, "_pc"}, PC, pc);
    chk({name, "_instr"}, IF_ID_Instr, ins);
    chk({name, "_plus4"}, IF_ID_PC_Plus4, p4);
    chk({name, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
  endtask

  initial begin
    reset = 1'b0;
    PCWrite = 0; IF_ID_Write = 0; Jump = 0; Jump_Target = 0;
    Branch_Taken = 0; Branch_Target = 0; Exception = 0; Instr = 0;
    #12;
    chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;

    run(32'h2008_0005);
    chk_if("fetch1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    run(32'h2008_0005);
    chk_if("fetch2", 32'h8, 32'h2008_0005, 32'h8, 1'b1);
    run(32'h2008_0005);
    chk_if("fetch3", 32'hC, 32'h2008_0005, 32'hC, 1'b1);
    run(32'h1111_0001);
    chk_if("fetch4", 32'h10, 32'h1111_0001, 32'h10, 1'b1);

    step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h2222_0002);
    chk_if("stall", 32'h10, 32'h1111_0001, 32'h10, 1'b1);
    run(32'h2222_0002);
    chk_if("resume", 32'h14, 32'h2222_0002, 32'h14, 1'b1);

    run(32'h3333_0003);
    run(32'h4444_0004);
    run(32'h5555_0005);
    chk_if("to_20", 32'h20, 32'h5555_0005, 32'h20, 1'b1);

    step(1, 1, 1, 32'h100, 0, 32'h0, 0, 32'h6666_0006);
    chk_if("jump", 32'h100, 32'h0, 32'h20, 1'b0);
    run(32'h7777_0007);
    chk_if("after_jump", 32'h104, 32'h7777_0007, 32'h104, 1'b1);

    step(0, 0, 1, 32'h80, 1, 32'h40, 0, 32'h8888_0008);
    chk_if("br_vs_jump_stall", 32'h40, 32'h0, 32'h104, 1'b0);

    step(1, 1, 0, 32'h0, 1, 32'h60, 1, 32'h9999_0009);
    chk_if("exception", 32'h8000_0004, 32'h0, 32'h104, 1'b0);

    step(1, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'hAAAA_000A);
    chk("jump_lowbits_pc", PC, 32'hFFFF_FFFC);
    run(32'hBBBB_000B);
    chk_if("wrap", 32'h0, 32'hBBBB_000B, 32'h0, 1'b1);

    step(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'hCCCC_000C);
    chk_if("mismatch", 32'h0, 32'hCCCC_000C, 32'h4, 1'b1);

    step(1, 1, 1, 32'h30, 0, 32'h0, 0, 32'hDDDD_000D);
    chk("to_30_pc", PC, 32'h30);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'hEEEE_000E);
    chk("stall3_pc", PC, 32'h30);
`ifdef FETCH_STALL_COUNT_EN
    chk("stall_count", Stall_Count, 32'd5);
`endif

    #1 reset = 1'b0;
    #1;
    chk_if("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_STALL_COUNT_EN
    chk("reset_count", Stall_Count, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    run(32'h1234_5678);
    chk_if("refetch", 32'h4, 32'h1234_5678, 32'h4, 1'b1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
